// File: rtl/serial_addsub_unit_pkg.sv
// Shared definitions for the bit-serial add/subtract unit:
// FSM state encoding and mode constants.
package serial_addsub_unit_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic ModeAdd = 1'b0;
    localparam logic ModeSub = 1'b1;

endpackage

// File: rtl/serial_addsub_unit_fa_fs_cell.sv
// Single-bit full adder / full subtractor cell, purely combinational.
// In subtract mode cin/cout carry the borrow.
module fa_fs_cell
    import serial_addsub_unit_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic d,
    output logic cout
);

    logic a_xor_b;

    always_comb begin
        a_xor_b = a ^ b;
        d       = a_xor_b ^ cin;
        if (sub == ModeSub) begin
            cout = (~a & b) | (~a_xor_b & cin);
        end else begin
            cout = (a & b) | (cin & a_xor_b);
        end
    end

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// fa_fs_cell with a carry/borrow flop, framed by valid/ready handshakes.
module serial_addsub_unit
    import serial_addsub_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic             c_q, c_d;
    logic             flag_q, flag_d;
    logic             cell_d, cell_cout;

    fa_fs_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .sub  (sub_q),
        .d    (cell_d),
        .cout (cell_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        c_d      = c_q;
        flag_d   = flag_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = cell_d;
                c_d              = cell_cout;
                cnt_d            = cnt_q + CntW'(1);
                // The result register only changes on completion so it holds
                // the previous answer while a new operation is in flight.
                if (cnt_q == LastCnt) begin
                    result_d = acc_d;
                    flag_d   = cell_cout;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            flag_q   <= flag_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign flag      = flag_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: directed vectors with literal
// expectations plus a per-cycle comparison against an arithmetic model.
module tb_serial_addsub_unit;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag;

    int n_tests = 0;
    int n_fail  = 0;

    serial_addsub_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted op is pending; after WIDTH edges its answer is visible
    // and stays until the output handshake. Outputs checked at every negedge.
    bit             m_on = 1'b0;
    bit             m_pend;
    int             m_age;
    logic [WIDTH-1:0] m_res, m_pres;
    logic           m_flag, m_pflag;

    initial begin
        logic [WIDTH:0] full;
        forever begin
            @(negedge clk);
            if (m_on) begin
                check("mon_in_ready", 32'(in_ready), 32'(!m_pend));
                check("mon_out_valid", 32'(out_valid), 32'(m_pend && m_age >= WIDTH));
                check("mon_result", 32'(result), 32'(m_res));
                check("mon_flag", 32'(flag), 32'(m_flag));
            end
            if (!rst_n) begin
                m_on   = 1'b1;
                m_pend = 1'b0;
                m_age  = 0;
                m_res  = '0;
                m_flag = 1'b0;
            end else if (m_on) begin
                if (!m_pend) begin
                    if (in_valid) begin
                        if (sub) full = {1'b0, a} - {1'b0, b};
                        else     full = {1'b0, a} + {1'b0, b};
                        m_pres  = full[WIDTH-1:0];
                        m_pflag = full[WIDTH];
                        m_pend  = 1'b1;
                        m_age   = 0;
                    end
                end else if (m_age >= WIDTH) begin
                    if (out_ready) m_pend = 1'b0;
                end else begin
                    m_age++;
                    if (m_age == WIDTH) begin
                        m_res  = m_pres;
                        m_flag = m_pflag;
                    end
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vs);
        bit acc;
        int guard;
        a = va; b = vb; sub = vs; in_valid = 1'b1;
        guard = 0;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            n_tests++; n_fail++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic vs, input logic [WIDTH-1:0] er, input logic ef);
        int lat;
        send(va, vb, vs);
        wait_valid(lat);
        check({name, "_latency"}, 32'(lat), WIDTH);
        check({name, "_result"}, 32'(result), 32'(er));
        check({name, "_flag"}, 32'(flag), 32'(ef));
        release_out();
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flag", 32'(flag), 32'd0);

        op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b1);
        op("sub_3c_3c", 8'h3C, 8'h3C, 1'b1, 8'h00, 1'b0);
        op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

        // Back-pressure in DONE with a competing in_valid
        send(8'h12, 8'h34, 1'b0);
        wait_valid(lat);
        a = 8'h77; b = 8'h11; sub = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(result), 32'h46);
            check("hold_flag", 32'(flag), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_in_ready", 32'(in_ready), 32'd1);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("late_accept_in_ready", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("late_accept_latency", 32'(lat), WIDTH);
        check("late_accept_result", 32'(result), 32'h66);
        check("late_accept_flag", 32'(flag), 32'd0);
        release_out();

        // Reset in the middle of a shift
        send(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flag", 32'(flag), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b1);

        // Random traffic, checked by the model
        for (int i = 0; i < 500; i++) begin
            bit hs;
            int guard;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            guard = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_valid && out_ready;
                @(posedge clk); #1;
                guard++;
            end while (!hs && guard < 100);
            out_ready = 1'b0;
            if (!hs) begin
                n_tests++; n_fail++;
                $display("FAIL rand_handshake_timeout: got none expected handshake");
            end
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
